// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the multi-channel arbiter-PUF evaluation controller.
//   puf_state_e : evaluation FSM states
//   SYNC_STAGES : depth of the per-channel arb_resp synchroniser
//   vote_w(n)   : width of a vote counter that must hold the value n
// Optional feature macro used by the users of this package: PUF_STAB_FLAG_EN.
// -----------------------------------------------------------------------------
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    FIRE   = 3'd3,
    SAMPLE = 3'd4,
    RELAX  = 3'd5,
    DONE   = 3'd6
  } puf_state_e;

  localparam int SYNC_STAGES = 2;

  // Counter width able to represent 0..n inclusive.
  function automatic int vote_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : puf_pkg

// File: rtl/puf_vote_ch.sv
// -----------------------------------------------------------------------------
// puf_vote_ch
// One PUF channel: synchronises the raw arbiter bit, counts the '1' votes over
// the excitations of one evaluation and decodes the majority (and, when
// PUF_STAB_FLAG_EN is defined, a non-unanimous flag) into held output bits.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   arb_in      raw arbiter output, asynchronous to clk
//   clear       zero the vote counter (start of an evaluation)
//   add_en      add the synced bit to the counter this cycle
//   latch       capture majority/stability decode into the outputs
//   response    majority-voted bit, held until the next latch
//   unstable    0 < votes < N_VOTE at latch (PUF_STAB_FLAG_EN only)
// -----------------------------------------------------------------------------
module puf_vote_ch
  import puf_pkg::*;
#(
  parameter int N_VOTE = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_in,
  input  logic clear,
  input  logic add_en,
  input  logic latch,
  output logic response
`ifdef PUF_STAB_FLAG_EN
  ,
  output logic unstable
`endif
);

  localparam int CW = vote_w(N_VOTE);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CW-1:0]          cnt;

  assign synced = sync[SYNC_STAGES-1];

  // Metastability synchroniser for the asynchronous arbiter output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], arb_in};
    end
  end

  // Vote counter; saturation guard keeps it inside 0..N_VOTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (add_en && synced && (cnt != CW'(N_VOTE))) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // Majority decode, held until the next evaluation finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      response <= 1'b0;
    end else if (latch) begin
      response <= (cnt > CW'(N_VOTE / 2));
    end else begin
      response <= response;
    end
  end

`ifdef PUF_STAB_FLAG_EN
  // Stability flag: set when the votes were not unanimous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unstable <= 1'b0;
    end else if (latch) begin
      unstable <= (cnt != '0) && (cnt != CW'(N_VOTE));
    end else begin
      unstable <= unstable;
    end
  end
`endif

endmodule : puf_vote_ch

// File: rtl/puf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// puf_eval_ctrl
// Multi-channel arbiter-PUF evaluation controller. On an accepted start it
// latches challenge/tune, fires the common excitation N_VOTE times, has each
// channel vote on its synchronised arbiter bit and returns an N_CH-bit
// majority response with a one-cycle done pulse.
// Optional feature: define PUF_STAB_FLAG_EN to add the per-channel unstable
// output (non-unanimous vote); without it the port and logic are absent.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (aborts an evaluation)
//   start        evaluation request, accepted only in IDLE
//   challenge    challenge word, captured on accepted start
//   tune_level   tune setting, captured on accepted start
//   arb_resp     raw arbiter outputs, one per channel, asynchronous
//   challenge_q  latched challenge to all chains
//   tune_q       latched tune to the decoders
//   excite       common rising-edge stimulus
//   busy         accepted start until done
//   done         one-cycle pulse, response valid from this cycle
//   response     majority-voted response, held until the next done
//   unstable     per-channel non-unanimous flag (PUF_STAB_FLAG_EN only)
// Shot timing: FIRE_CYC cycles excite high, 3 sample cycles (excite still
// high, count on the third), SETTLE_CYC relax cycles with excite low.
// -----------------------------------------------------------------------------
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int N_CB       = 64,
  parameter int K          = 5,
  parameter int N_CH       = 8,
  parameter int N_VOTE     = 7,
  parameter int SETTLE_CYC = 4,
  parameter int FIRE_CYC   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_CB-1:0] challenge,
  input  logic [K-1:0]    tune_level,
  input  logic [N_CH-1:0] arb_resp,
  output logic [N_CB-1:0] challenge_q,
  output logic [K-1:0]    tune_q,
  output logic            excite,
  output logic            busy,
  output logic            done,
  output logic [N_CH-1:0] response
`ifdef PUF_STAB_FLAG_EN
  ,
  output logic [N_CH-1:0] unstable
`endif
);

  // Timer must reach the longest phase: settle, fire, or the 3 sample cycles.
  localparam int TMAX_A = (SETTLE_CYC > FIRE_CYC) ? SETTLE_CYC : FIRE_CYC;
  localparam int TMAX   = (TMAX_A > 3) ? TMAX_A : 3;
  localparam int TW     = $clog2(TMAX + 1);

  if (((N_VOTE % 2) == 0) || (N_VOTE < 1) || (N_VOTE > 255)) begin : g_bad_vote
    $error("puf_eval_ctrl: N_VOTE must be odd and within 1..255");
  end
  if ((SETTLE_CYC < 1) || (FIRE_CYC < 1)) begin : g_bad_timing
    $error("puf_eval_ctrl: SETTLE_CYC and FIRE_CYC must be at least 1");
  end

  puf_state_e    state;
  logic [TW-1:0] tmr;
  logic [7:0]    fires;

  logic settle_end;
  logic sample_end;
  logic last_shot;
  logic cnt_clear;
  logic cnt_add;
  logic resp_latch;

  assign settle_end = (tmr == TW'(SETTLE_CYC - 1));
  assign sample_end = (tmr == TW'(2));
  assign last_shot  = (fires >= 8'(N_VOTE));
  assign cnt_clear  = (state == LOAD);
  assign cnt_add    = (state == SAMPLE) && sample_end;
  // Channels capture their decode on the same edge the FSM enters DONE.
  assign resp_latch = (state == RELAX) && settle_end && last_shot;

  // Evaluation FSM with registered handshake, excitation and latched inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmr         <= '0;
      fires       <= 8'd0;
      challenge_q <= '0;
      tune_q      <= '0;
      excite      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            busy        <= 1'b1;
            challenge_q <= challenge;
            tune_q      <= tune_level;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          state  <= SETTLE;
          tmr    <= '0;
          fires  <= 8'd0;
          excite <= 1'b0;
        end
        SETTLE: begin
          if (settle_end) begin
            state  <= FIRE;
            tmr    <= '0;
            excite <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        FIRE: begin
          if (tmr == TW'(FIRE_CYC - 1)) begin
            state <= SAMPLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        SAMPLE: begin
          if (sample_end) begin
            state  <= RELAX;
            tmr    <= '0;
            excite <= 1'b0;
            fires  <= fires + 8'd1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        RELAX: begin
          if (settle_end) begin
            tmr <= '0;
            if (last_shot) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state  <= FIRE;
              excite <= 1'b1;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        DONE: begin
          // start seen here is deliberately dropped.
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          excite <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    puf_vote_ch #(
      .N_VOTE(N_VOTE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .arb_in  (arb_resp[i]),
      .clear   (cnt_clear),
      .add_en  (cnt_add),
      .latch   (resp_latch),
      .response(response[i])
`ifdef PUF_STAB_FLAG_EN
      ,
      .unstable(unstable[i])
`endif
    );
  end

endmodule : puf_eval_ctrl

// File: tb/tb_puf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_eval_ctrl
// Directed bench for puf_eval_ctrl: a default-parameter instance and a
// minimal-timing instance (N_VOTE=1, SETTLE_CYC=1, FIRE_CYC=1). Expected
// responses are queued when start is driven and popped at done.
// -----------------------------------------------------------------------------
module tb_puf_eval_ctrl;

  typedef struct packed {
    logic [7:0] resp;
    logic [7:0] unst;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] challenge;
  logic [4:0]  tune_level;
  logic [7:0]  arb_resp;
  logic [63:0] challenge_q;
  logic [4:0]  tune_q;
  logic        excite;
  logic        busy;
  logic        done;
  logic [7:0]  response;
  logic [7:0]  unst_obs;

  logic        start6;
  logic [7:0]  arb6;
  logic [63:0] challenge_q6;
  logic [4:0]  tune_q6;
  logic        excite6;
  logic        busy6;
  logic        done6;
  logic [7:0]  response6;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

`ifdef PUF_STAB_FLAG_EN
  logic [7:0] unstable;
  logic [7:0] unstable6;
  assign unst_obs = unstable;
`else
  assign unst_obs = 8'h00;
`endif

  puf_eval_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .challenge  (challenge),
    .tune_level (tune_level),
    .arb_resp   (arb_resp),
    .challenge_q(challenge_q),
    .tune_q     (tune_q),
    .excite     (excite),
    .busy       (busy),
    .done       (done),
    .response   (response)
`ifdef PUF_STAB_FLAG_EN
    ,
    .unstable   (unstable)
`endif
  );

  puf_eval_ctrl #(
    .N_VOTE(1), .SETTLE_CYC(1), .FIRE_CYC(1)
  ) dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start6),
    .challenge  (64'h0123_4567_89AB_CDEF),
    .tune_level (5'd3),
    .arb_resp   (arb6),
    .challenge_q(challenge_q6),
    .tune_q     (tune_q6),
    .excite     (excite6),
    .busy       (busy6),
    .done       (done6),
    .response   (response6)
`ifdef PUF_STAB_FLAG_EN
    ,
    .unstable   (unstable6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One evaluation on the default instance. pat drives channel 0 per shot when
  // use_pat is set; disturb re-pulses start and changes challenge mid-run;
  // abort_at > 0 pulls rst_n low at that cycle.
  task automatic run_eval(input logic [7:0] arb, input logic [6:0] pat, input bit use_pat,
                          input bit disturb, input int abort_at,
                          input logic [63:0] chal, input logic [4:0] tune);
    int   cyc;
    int   n_exc;
    int   extra_done;
    logic prev_exc;
    exp_t e;
    exp_t got;
    int   ones;

    ones = $countones(pat);
    e.resp = use_pat ? {arb[7:1], (ones > 3) ? 1'b1 : 1'b0} : arb;
`ifdef PUF_STAB_FLAG_EN
    e.unst = (use_pat && (ones != 0) && (ones != 7)) ? 8'h01 : 8'h00;
`else
    e.unst = 8'h00;
`endif
    @(negedge clk);
    arb_resp = arb;
    if (use_pat) arb_resp[0] = pat[0];
    challenge  = chal;
    tune_level = tune;
    start      = 1'b1;
    exp_q.push_back(e);
    cyc      = 0;
    n_exc    = 0;
    prev_exc = excite;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (excite && !prev_exc) begin
        n_exc++;
        if (use_pat && n_exc <= 7) arb_resp[0] = pat[n_exc-1];
      end
      prev_exc = excite;
      if (disturb) begin
        if (cyc == 10) start = 1'b1;
        if (cyc == 11) start = 1'b0;
        if (cyc == 20) begin
          challenge  = ~chal;
          tune_level = ~tune;
        end
      end
      if (abort_at == cyc) begin
        check("busy_before_abort", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_excite", 64'(excite), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_response", 64'(response), 64'd0);
        check("abort_unstable", 64'(unst_obs), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        repeat (80) begin
          @(negedge clk);
          if (done) extra_done++;
        end
        check("abort_no_done", 64'(extra_done), 64'd0);
        return;
      end
      if (done) break;
    end
    check("done_seen", 64'(done), 64'd1);
    if (!done) return;
    check("latency", 64'(cyc), 64'd69);
    check("excite_pulses", 64'(n_exc), 64'd7);
    check("busy_at_done", 64'(busy), 64'd0);
    check("challenge_q", challenge_q, chal);
    check("tune_q", 64'(tune_q), 64'(tune));
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      check("response", 64'(response), 64'(got.resp));
      check("unstable", 64'(unst_obs), 64'(got.unst));
    end
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 64'(done), 64'd0);
    check("response_held", 64'(response), 64'(e.resp));
    if (disturb) begin
      extra_done = 0;
      repeat (80) begin
        @(negedge clk);
        if (done || busy) extra_done++;
      end
      check("no_second_eval", 64'(extra_done), 64'd0);
    end
  endtask

  // One evaluation on the minimal-timing instance.
  task automatic run6(input logic [7:0] arb);
    int cyc;
    @(negedge clk);
    arb6 = arb;
    repeat (3) @(negedge clk);
    start6 = 1'b1;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start6 = 1'b0;
      if (done6) break;
    end
    check("min_done_seen", 64'(done6), 64'd1);
    check("min_latency", 64'(cyc), 64'd8);
    check("min_response", 64'(response6), 64'(arb));
    check("min_busy", 64'(busy6), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start6     = 1'b0;
    challenge  = 64'd0;
    tune_level = 5'd0;
    arb_resp   = 8'hFF;
    arb6       = 8'hFF;

    // Reset state with arbiter inputs all high.
    repeat (3) @(negedge clk);
    check("rst_excite", 64'(excite), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_response", 64'(response), 64'd0);
    check("rst_unstable", 64'(unst_obs), 64'd0);
    check("rst_challenge_q", challenge_q, 64'd0);
    check("rst_tune_q", 64'(tune_q), 64'd0);
    check("rst_response6", 64'(response6), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_excite", 64'(excite), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Constant arbiter pattern.
    run_eval(8'hA5, 7'd0, 1'b0, 1'b0, 0, 64'hDEAD_BEEF_CAFE_F00D, 5'd17);
    // Channel 0 votes 1,0,1,1,0,1,0.
    run_eval(8'h5A, 7'b0101101, 1'b1, 1'b0, 0, 64'h1111_2222_3333_4444, 5'd9);
    // Channel 0 votes 0,1,0,0,1,0,0 (minority ones).
    run_eval(8'hFF, 7'b0010010, 1'b1, 1'b0, 0, 64'h0F0F_0F0F_0F0F_0F0F, 5'd30);
    // Ignored restarts and mid-run challenge change.
    run_eval(8'h3C, 7'd0, 1'b0, 1'b1, 0, 64'hA5A5_5A5A_FFFF_0000, 5'd4);
    // Abort by reset mid-evaluation, then a normal evaluation.
    run_eval(8'hC3, 7'd0, 1'b0, 1'b0, 30, 64'h1234_5678_9ABC_DEF0, 5'd1);
    run_eval(8'h81, 7'd0, 1'b0, 1'b0, 0, 64'h0000_0000_0000_0001, 5'd31);

    // Minimal timing instance.
    run6(8'h3C);
    run6(8'hC3);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_puf_eval_ctrl
